// File: rtl/operand_arb.sv
// Two-requester round-robin front end for a fixed-latency ALU: registers the winner's
// operands onto the operand mux, launches the ALU, waits ALU_LAT cycles and returns the result.
//
// state | meaning
// IDLE  | arbitrating; req_ready high for the winner only
// ISSUE | alu_start pulse, counter loaded ALU_LAT-1
// WAIT  | counting down ALU latency; result captured on the final edge
// RESP  | resp_valid to owner until its resp_ready handshake
module operand_arb #(
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  input  logic [8:0]  req0_imm,
  input  logic [8:0]  req1_imm,
  input  logic        req0_use_imm,
  input  logic        req1_use_imm,
  output logic [31:0] mux_data1,
  output logic [8:0]  mux_data2,
  output logic        mux_sel,
  output logic        alu_start,
  input  logic [31:0] alu_result,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mux_data1_q, mux_data1_d;
  logic [8:0]  mux_data2_q, mux_data2_d;
  logic        mux_sel_q, mux_sel_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic        win;
  logic        accept;

  // Pointer only matters on a tie; a lone requester always wins.
  always_comb begin
    win = ~req_valid[0];
    if (req_valid == 2'b11) begin
      win = ptr_q;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && req_valid != 2'b00) begin
      req_ready = win ? 2'b10 : 2'b01;
    end
  end

  assign accept = |(req_valid & req_ready);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mux_data1_d = mux_data1_q;
    mux_data2_d = mux_data2_q;
    mux_sel_d   = mux_sel_q;
    resp_data_d = resp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          mux_data1_d = win ? req1_data    : req0_data;
          mux_data2_d = win ? req1_imm     : req0_imm;
          mux_sel_d   = win ? req1_use_imm : req0_use_imm;
          owner_d     = win;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          resp_data_d = alu_result;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready[owner_q]) begin
          ptr_d   = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= 4'd0;
      mux_data1_q <= 32'd0;
      mux_data2_q <= 9'd0;
      mux_sel_q   <= 1'b0;
      resp_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mux_data1_q <= mux_data1_d;
      mux_data2_q <= mux_data2_d;
      mux_sel_q   <= mux_sel_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Decoded from the state flop so reset removes the strobe without waiting for a clock.
  assign alu_start  = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign mux_data1  = mux_data1_q;
  assign mux_data2  = mux_data2_q;
  assign mux_sel    = mux_sel_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_operand_arb.sv
// Directed bench for operand_arb: main instance at ALU_LAT=2 plus ALU_LAT=1 and 15 instances
// sharing the same stimulus for the latency sweep.
module tb_operand_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [31:0] req0_data = 32'd0, req1_data = 32'd0;
  logic [8:0]  req0_imm = 9'd0, req1_imm = 9'd0;
  logic        req0_use_imm = 1'b0, req1_use_imm = 1'b0;
  logic [1:0]  resp_ready = 2'b00;
  logic [15:0] cyc = 16'd0;
  logic [31:0] alu_result;

  logic [1:0]  req_ready, req_ready_l1, req_ready_l15;
  logic [31:0] mux_data1, mux_data1_l1, mux_data1_l15;
  logic [8:0]  mux_data2, mux_data2_l1, mux_data2_l15;
  logic        mux_sel, mux_sel_l1, mux_sel_l15;
  logic        alu_start, alu_start_l1, alu_start_l15;
  logic [1:0]  resp_valid, resp_valid_l1, resp_valid_l15;
  logic [31:0] resp_data, resp_data_l1, resp_data_l15;
  logic        busy, busy_l1, busy_l15;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;
  // Result changes every cycle so the capture edge is observable.
  assign alu_result = {16'hA5A5, cyc};

  operand_arb #(.ALU_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_data(req0_data), .req1_data(req1_data), .req0_imm(req0_imm), .req1_imm(req1_imm),
    .req0_use_imm(req0_use_imm), .req1_use_imm(req1_use_imm),
    .mux_data1(mux_data1), .mux_data2(mux_data2), .mux_sel(mux_sel), .alu_start(alu_start),
    .alu_result(alu_result), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .busy(busy));

  operand_arb #(.ALU_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_l1),
    .req0_data(req0_data), .req1_data(req1_data), .req0_imm(req0_imm), .req1_imm(req1_imm),
    .req0_use_imm(req0_use_imm), .req1_use_imm(req1_use_imm),
    .mux_data1(mux_data1_l1), .mux_data2(mux_data2_l1), .mux_sel(mux_sel_l1),
    .alu_start(alu_start_l1), .alu_result(alu_result), .resp_valid(resp_valid_l1),
    .resp_ready(resp_ready), .resp_data(resp_data_l1), .busy(busy_l1));

  operand_arb #(.ALU_LAT(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_l15),
    .req0_data(req0_data), .req1_data(req1_data), .req0_imm(req0_imm), .req1_imm(req1_imm),
    .req0_use_imm(req0_use_imm), .req1_use_imm(req1_use_imm),
    .mux_data1(mux_data1_l15), .mux_data2(mux_data2_l15), .mux_sel(mux_sel_l15),
    .alu_start(alu_start_l15), .alu_result(alu_result), .resp_valid(resp_valid_l15),
    .resp_ready(resp_ready), .resp_data(resp_data_l15), .busy(busy_l15));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    resp_ready = 2'b00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Advances until the main instance raises resp_valid; reports edges taken and whether it did.
  task automatic wait_resp(output int n, output bit ok);
    n = 0;
    while (resp_valid == 2'b00 && n < 40) begin
      tick();
      n++;
    end
    ok = (resp_valid != 2'b00);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (alu_start !== 1'b0) begin n_err++; $display("FAIL reset_alu_start: got %b want 0", alu_start); end
    n_vec++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
    n_vec++; if ({mux_data1, mux_data2, mux_sel} !== 42'd0) begin n_err++; $display("FAIL reset_mux: got %h/%h/%b want 0", mux_data1, mux_data2, mux_sel); end
    n_vec++; if (resp_data !== 32'd0) begin n_err++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
    n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready_idle: got %b want 00", req_ready); end
    rst_n = 1'b1;
    tick();
    req_valid = 2'b10;
    #1;
    n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL lone_req1_ready: got %b want 10", req_ready); end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_single();
    logic [15:0] a;
    do_reset();
    req0_data = 32'h0000_0010; req0_imm = 9'h1FF; req0_use_imm = 1'b1;
    req1_data = 32'h5555_5555; req1_imm = 9'h033; req1_use_imm = 1'b0;
    req_valid = 2'b01;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_req_ready: got %b want 01", req_ready); end
    tick();
    a = cyc;
    req_valid = 2'b00;
    n_vec++; if ({mux_sel, mux_data2, mux_data1} !== {1'b1, 9'h1FF, 32'h0000_0010}) begin
      n_err++; $display("FAIL single_mux: got sel=%b d2=%h d1=%h want 1/1ff/00000010", mux_sel, mux_data2, mux_data1); end
    n_vec++; if ({alu_start, busy, req_ready} !== 4'b1100) begin n_err++; $display("FAIL single_issue: got start=%b busy=%b rdy=%b", alu_start, busy, req_ready); end
    req0_data = 32'hDEAD_BEEF; req0_imm = 9'h000; req0_use_imm = 1'b0;
    tick();
    n_vec++; if ({alu_start, resp_valid} !== 3'b000) begin n_err++; $display("FAIL single_e1: got start=%b rv=%b want 0/00", alu_start, resp_valid); end
    tick();
    n_vec++; if (resp_valid !== 2'b00) begin n_err++; $display("FAIL single_e2: got rv=%b want 00", resp_valid); end
    tick();
    n_vec++; if (resp_valid !== 2'b01) begin n_err++; $display("FAIL single_e3_rv: got %b want 01", resp_valid); end
    n_vec++; if (resp_data !== {16'hA5A5, 16'(a + 16'd2)}) begin n_err++; $display("FAIL single_rdata: got %h want %h", resp_data, {16'hA5A5, 16'(a + 16'd2)}); end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    n_vec++; if ({busy, resp_valid} !== 3'b000) begin n_err++; $display("FAIL single_done: got busy=%b rv=%b", busy, resp_valid); end
    tick();
    n_vec++; if ({mux_sel, mux_data2, mux_data1} !== {1'b1, 9'h1FF, 32'h0000_0010}) begin
      n_err++; $display("FAIL single_hold: got sel=%b d2=%h d1=%h", mux_sel, mux_data2, mux_data1); end
  endtask

  task automatic test_simultaneous();
    int n; bit ok;
    do_reset();
    req0_data = 32'h1111_0000; req0_use_imm = 1'b0;
    req1_data = 32'h2222_0000; req1_use_imm = 1'b0;
    req_valid = 2'b11;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL sim_first_grant: got %b want 01", req_ready); end
    tick();
    n_vec++; if (mux_data1 !== 32'h1111_0000) begin n_err++; $display("FAIL sim_first_data: got %h want 11110000", mux_data1); end
    wait_resp(n, ok);
    n_vec++; if (!ok || resp_valid !== 2'b01) begin n_err++; $display("FAIL sim_first_resp: got %b want 01", resp_valid); end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    n_vec++; if ({busy, req_ready} !== 3'b010) begin n_err++; $display("FAIL sim_second_grant: got busy=%b rdy=%b want 0/10", busy, req_ready); end
    tick();
    n_vec++; if ({busy, mux_data1} !== {1'b1, 32'h2222_0000}) begin n_err++; $display("FAIL sim_second_data: got %b/%h", busy, mux_data1); end
    req_valid = 2'b00;
    wait_resp(n, ok);
    n_vec++; if (!ok || resp_valid !== 2'b10) begin n_err++; $display("FAIL sim_second_resp: got %b want 10", resp_valid); end
    resp_ready = 2'b10;
    tick();
    resp_ready = 2'b00;
  endtask

  task automatic test_fairness();
    int n; bit ok;
    logic [31:0] exp_d;
    do_reset();
    req0_data = 32'hAAAA_0000; req1_data = 32'hBBBB_0001;
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_d = (i % 2 == 1) ? 32'hBBBB_0001 : 32'hAAAA_0000;
      n_vec++; if (mux_data1 !== exp_d) begin n_err++; $display("FAIL fair_grant_%0d: got %h want %h", i, mux_data1, exp_d); end
      wait_resp(n, ok);
      n_vec++; if (!ok || resp_valid !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL fair_resp_%0d: got %b", i, resp_valid); end
      resp_ready = 2'b11;
      tick();
      resp_ready = 2'b00;
    end
    req_valid = 2'b00;
    #1;
  endtask

  task automatic test_back_pressure();
    int n; bit ok;
    logic [15:0] a;
    logic [31:0] exp_d;
    do_reset();
    req0_data = 32'h0C0C_0C0C; req1_data = 32'h0D0D_0D0D;
    req_valid = 2'b01;
    tick();
    a = cyc;
    req_valid = 2'b11;
    resp_ready = 2'b11;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++; if ({busy, resp_valid} !== 3'b100) begin n_err++; $display("FAIL bp_early_ready_%0d: got busy=%b rv=%b want 1/00", k, busy, resp_valid); end
    end
    resp_ready = 2'b10;
    tick();
    exp_d = {16'hA5A5, 16'(a + 16'd2)};
    n_vec++; if ({resp_valid, resp_data} !== {2'b01, exp_d}) begin n_err++; $display("FAIL bp_resp: got %b/%h want 01/%h", resp_valid, resp_data, exp_d); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_vec++; if ({resp_valid, resp_data, req_ready, alu_start} !== {2'b01, exp_d, 2'b00, 1'b0}) begin
        n_err++; $display("FAIL bp_hold_%0d: got rv=%b rd=%h rdy=%b start=%b", k, resp_valid, resp_data, req_ready, alu_start); end
    end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_release: got busy=%b want 0", busy); end
    tick();
    n_vec++; if ({busy, mux_data1} !== {1'b1, 32'h0D0D_0D0D}) begin n_err++; $display("FAIL bp_pending_req1: got %b/%h", busy, mux_data1); end
    req_valid = 2'b00;
    wait_resp(n, ok);
    resp_ready = 2'b11;
    tick();
    resp_ready = 2'b00;
  endtask

  task automatic test_withdraw();
    do_reset();
    req_valid = 2'b01;
    #3;
    req_valid = 2'b00;
    tick();
    n_vec++; if ({busy, alu_start} !== 2'b00) begin n_err++; $display("FAIL withdraw: got busy=%b start=%b want 0/0", busy, alu_start); end
  endtask

  task automatic test_reset_abort();
    int n; bit ok; bit seen;
    do_reset();
    req0_data = 32'h0000_1234; req0_imm = 9'h055; req0_use_imm = 1'b1;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_resp(n, ok);
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    req1_data = 32'hCAFE_F00D; req1_imm = 9'h0AB; req1_use_imm = 1'b1;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    n_vec++; if ({busy, alu_start, resp_valid} !== 4'b1000) begin n_err++; $display("FAIL abort_in_wait: got busy=%b start=%b rv=%b", busy, alu_start, resp_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({busy, alu_start, resp_valid, mux_sel, mux_data2, mux_data1, resp_data} !== 78'd0) begin
      n_err++; $display("FAIL abort_wait_outputs: got busy=%b start=%b rv=%b sel=%b d2=%h d1=%h rd=%h",
                        busy, alu_start, resp_valid, mux_sel, mux_data2, mux_data1, resp_data); end
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (resp_valid != 2'b00) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_resp: got resp pulse=%b want 0", seen); end
    req_valid = 2'b11;
    #1;
    n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL abort_ptr_reset: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    n_vec++; if (alu_start !== 1'b1) begin n_err++; $display("FAIL abort_issue_start: got %b want 1", alu_start); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({alu_start, busy} !== 2'b00) begin n_err++; $display("FAIL abort_issue_async: got start=%b busy=%b want 0/0", alu_start, busy); end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency_sweep();
    logic [15:0] a;
    int w2, w1, w15;
    bit d2, d1, d15;
    logic [31:0] r2, r1, r15;
    do_reset();
    w2 = 0; w1 = 0; w15 = 0; d2 = 0; d1 = 0; d15 = 0;
    r2 = '0; r1 = '0; r15 = '0;
    req0_data = 32'h0000_00F0; req0_use_imm = 1'b0;
    req_valid = 2'b01;
    tick();
    a = cyc;
    req_valid = 2'b00;
    for (int k = 0; k < 40 && !(d1 && d2 && d15); k++) begin
      if (!d2)  begin if (resp_valid != 2'b00)     begin d2 = 1;  r2 = resp_data;      end else if (busy && !alu_start)         w2++;  end
      if (!d1)  begin if (resp_valid_l1 != 2'b00)  begin d1 = 1;  r1 = resp_data_l1;   end else if (busy_l1 && !alu_start_l1)   w1++;  end
      if (!d15) begin if (resp_valid_l15 != 2'b00) begin d15 = 1; r15 = resp_data_l15; end else if (busy_l15 && !alu_start_l15) w15++; end
      tick();
    end
    n_vec++; if (!d1 || w1 != 1) begin n_err++; $display("FAIL lat1_wait: got done=%b len=%0d want 1", d1, w1); end
    n_vec++; if (r1 !== {16'hA5A5, 16'(a + 16'd1)}) begin n_err++; $display("FAIL lat1_data: got %h want %h", r1, {16'hA5A5, 16'(a + 16'd1)}); end
    n_vec++; if (!d2 || w2 != 2) begin n_err++; $display("FAIL lat2_wait: got done=%b len=%0d want 2", d2, w2); end
    n_vec++; if (!d15 || w15 != 15) begin n_err++; $display("FAIL lat15_wait: got done=%b len=%0d want 15", d15, w15); end
    n_vec++; if (r15 !== {16'hA5A5, 16'(a + 16'd15)}) begin n_err++; $display("FAIL lat15_data: got %h want %h", r15, {16'hA5A5, 16'(a + 16'd15)}); end
    resp_ready = 2'b11;
    tick();
    resp_ready = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_back_pressure();
    test_withdraw();
    test_reset_abort();
    test_latency_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_arb.md
OPERAND_ARB -- requirements
Module: operand_arb

Interface
REQ-001 Parameter: ALU_LAT, default 2, ALU cycles from alu_start to valid alu_result; legal range 1..15.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset; assertion clears state immediately, deassertion synchronous to clk.
REQ-004 req_valid  in  2  per-requester operation request; bit i = requester i.
REQ-005 req_ready  out  2  per-requester accept; transfer on req_valid[i] & req_ready[i] at rising edge.
REQ-006 req0_data, req1_data  in  32 each  register operand of requester 0/1.
REQ-007 req0_imm, req1_imm  in  9 each  immediate operand of requester 0/1.
REQ-008 req0_use_imm, req1_use_imm  in  1 each  1 = immediate selected as operand.
REQ-009 mux_data1  out  32  registered register operand to operand mux Data1.
REQ-010 mux_data2  out  9  registered immediate to operand mux Data2 (mux zero-extends).
REQ-011 mux_sel  out  1  registered operand-mux select; 1 = immediate.
REQ-012 alu_start  out  1  one-cycle ALU launch strobe.
REQ-013 alu_result  in  32  ALU output, valid ALU_LAT cycles after alu_start.
REQ-014 resp_valid  out  2  result available to owning requester; at most one bit high.
REQ-015 resp_ready  in  2  per-requester result accept.
REQ-016 resp_data  out  32  captured result.
REQ-017 busy  out  1  high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; unreachable encodings SHALL return to IDLE next edge.
REQ-019 IDLE: req_ready SHALL be high only for the arbitration winner (combinational from req_valid and pointer); all other states req_ready = 2'b00.
REQ-020 Arbitration SHALL be round-robin: pointer names the preferred requester; if only one req_valid bit high, that requester wins.
REQ-021 On accept edge: mux_data1, mux_data2, mux_sel SHALL load the winner's data, imm, use_imm; owner register SHALL record winner; FSM -> ISSUE.
REQ-022 mux_data1/mux_data2/mux_sel SHALL hold their value from accept until the next accept, including through IDLE.
REQ-023 ISSUE lasts exactly one cycle with alu_start = 1; FSM -> WAIT, counter loaded ALU_LAT-1.
REQ-024 WAIT lasts exactly ALU_LAT cycles (4-bit down-counter); on the final WAIT edge resp_data SHALL capture alu_result; FSM -> RESP.
REQ-025 RESP: resp_valid[owner] = 1, resp_data stable until resp_ready[owner] sampled high; resp_ready of non-owner ignored.
REQ-026 On RESP handshake edge: pointer SHALL move to the non-owner; FSM -> IDLE; resp_valid clears.
REQ-027 Latency: resp_valid rises ALU_LAT+1 edges after the accept edge; minimum request-to-request spacing ALU_LAT+3 cycles.
REQ-028 req_valid withdrawn before acceptance SHALL have no effect; requests arriving while busy wait (not dropped, not accepted).
REQ-029 resp_ready high in IDLE, ISSUE or WAIT SHALL be ignored.

Reset
REQ-030 rst_n low SHALL force: state IDLE, pointer = requester 0, owner 0, counter 0, mux_data1 0, mux_data2 0, mux_sel 0, resp_data 0, alu_start 0, resp_valid 2'b00, busy 0.
REQ-031 Reset mid-operation SHALL abort the operation without any resp_valid pulse; alu_start SHALL drop asynchronously.

Verification
REQ-032 Single request: req0 data=32'h0000_0010, imm=9'h1FF, use_imm=1, ALU_LAT=2 -> mux_sel=1, mux_data2=9'h1FF after accept; alu_start one cycle; resp_valid=2'b01 three edges after accept with resp_data=alu_result.
REQ-033 Simultaneous requests after reset: both req_valid high -> req0 granted first, req1 granted on first IDLE cycle after req0's response handshake.
REQ-034 Fairness: both requesters continuously valid for 6 operations -> grant order 0,1,0,1,0,1.
REQ-035 Back-pressure: resp_ready held low 5 cycles in RESP -> resp_valid and resp_data stable, req_ready stays 2'b00, no new alu_start.
REQ-036 Reset in WAIT: assert rst_n low during WAIT -> all outputs at REQ-030 values immediately; no resp_valid after release until a new request completes.
REQ-037 Latency sweep ALU_LAT=1 and 15 -> WAIT length 1 and 15 cycles; resp_data equals alu_result on the final WAIT edge.
